// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-192 key-schedule constants, controller state
//                encoding, round-constant table and the word -> group/offset
//                mapping used by the round-key read mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR      = 12;            // AES-192 rounds; round keys 0..NR
    localparam int NK      = 6;             // key length in 32-bit words
    localparam int WORD_W  = 32;
    localparam int NSTEP   = 8;             // expansion steps, 6 new words each
    localparam int NGROUP  = NSTEP + 1;     // 9 groups x 6 words = 54 words
    localparam int GROUP_W = NK * WORD_W;   // 192
    localparam int STEP_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Location of one schedule word inside the group register file.
    typedef struct packed {
        logic [3:0] grp;
        logic [2:0] off;     // 0 = most significant word of the group
    } word_loc_t;

    function automatic logic [7:0] rc_byte(input logic [STEP_W-1:0] idx);
        logic [7:0] rc;
        case (idx)
            3'd0: rc = 8'h01;
            3'd1: rc = 8'h02;
            3'd2: rc = 8'h04;
            3'd3: rc = 8'h08;
            3'd4: rc = 8'h10;
            3'd5: rc = 8'h20;
            3'd6: rc = 8'h40;
            3'd7: rc = 8'h80;
        endcase
        return rc;
    endfunction

    // Schedule word w[widx] lives in group widx/6 at offset widx%6.
    function automatic word_loc_t word_loc(input logic [5:0] widx);
        word_loc_t loc;
        loc.grp = 4'(widx / 6);
        loc.off = 3'(widx % 6);
        return loc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_expansion_192v.sv
`default_nettype none
// ============================================================================
//  Module      : key_expansion_192v
//  Description : One combinational AES-192 key-expansion step. Takes six
//                words w[6i..6i+5] and produces w[6i+6..6i+11].
//  Ports       : key_in  [191:0] previous group, w[6i] at [191:160]
//                rcon    [31:0]  round constant {RC[i], 24'h0}
//                key_out [191:0] next group, same packing
//  Revision    : 1.0 - initial release
// ============================================================================
module key_expansion_192v (
    input  logic [191:0] key_in,
    input  logic [31:0]  rcon,
    output logic [191:0] key_out
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the field inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w_in  [0:5];
    logic [31:0] w_out [0:5];
    logic [31:0] w_rot;
    logic [31:0] w_temp;

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_in[k] = key_in[191 - 32*k -: 32];
        end
        w_rot  = {w_in[5][23:0], w_in[5][31:24]};
        w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ rcon;
        w_out[0] = w_in[0] ^ w_temp;
        for (int k = 1; k < 6; k++) begin
            w_out[k] = w_in[k] ^ w_out[k-1];
        end
        key_out = {w_out[0], w_out[1], w_out[2], w_out[3], w_out[4], w_out[5]};
    end

endmodule
`default_nettype wire

// File: rtl/aes192_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes192_key_schedule_ctrl
//  Description : Iterative AES-192 key-schedule controller. Loads a 192-bit
//                key, runs one key_expansion_192v step per cycle for 8 steps,
//                stores 54 words as 9 groups and serves round keys 0..12
//                through a registered read port.
//  Ports       : clk, rst (async, active high)
//                start, clear, key_in[191:0]
//                busy, done (pulse), keys_valid
//                rk_addr[3:0] -> rk_data[127:0] (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes192_key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clear,
    input  logic [191:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    state_t               r_state;
    logic [STEP_W-1:0]    r_step;
    logic [GROUP_W-1:0]   r_grp [0:NGROUP-1];
    logic                 r_busy;
    logic                 r_done;
    logic                 r_keys_valid;
    logic [127:0]         r_rk_data;

    logic [GROUP_W-1:0]   w_next;
    logic [31:0]          w_rcon;
    logic                 w_load;
    logic [3:0]           w_rk_idx;
    word_loc_t            w_loc;
    logic [GROUP_W-1:0]   w_grp_sel;
    logic [127:0]         w_rk_sel;

    assign w_rcon = {rc_byte(r_step), 24'h000000};
    assign w_load = start && !clear && (r_state != EXPAND);

    key_expansion_192v u_step (
        .key_in  (r_grp[{1'b0, r_step}]),
        .rcon    (w_rcon),
        .key_out (w_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int g = 0; g < NGROUP; g++) r_grp[g] <= '0;
        end else if (clear) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int g = 0; g < NGROUP; g++) r_grp[g] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_grp[0]     <= key_in;
                        r_step       <= '0;
                        r_state      <= EXPAND;
                        r_busy       <= 1'b1;
                        r_keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    for (int g = 1; g < NGROUP; g++) begin
                        if (r_step == STEP_W'(g - 1)) r_grp[g] <= w_next;
                    end
                    // Counter holds at the last step rather than wrapping.
                    if (r_step == STEP_W'(NSTEP - 1)) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_keys_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Round key r = w[4r..4r+3]; the four words may straddle two groups.
    // Out-of-range addresses are folded to 0 here and blanked at the register.
    always_comb begin
        w_rk_idx  = (rk_addr > 4'(NR)) ? 4'd0 : rk_addr;
        w_rk_sel  = '0;
        w_loc     = '0;
        w_grp_sel = '0;
        for (int j = 0; j < 4; j++) begin
            w_loc     = word_loc({w_rk_idx, 2'b00} + 6'(j));
            w_grp_sel = r_grp[w_loc.grp] << (WORD_W * w_loc.off);
            w_rk_sel[127 - 32*j -: 32] = w_grp_sel[GROUP_W-1 -: WORD_W];
        end
    end

    // Blanking on load/clear keeps stale keys off the port from the first
    // cycle of a re-key, not one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk_data <= '0;
        end else if (clear || w_load || !r_keys_valid || (rk_addr > 4'(NR))) begin
            r_rk_data <= '0;
        end else begin
            r_rk_data <= w_rk_sel;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign rk_data    = r_rk_data;

endmodule
`default_nettype wire

// File: doc/aes192_key_schedule_ctrl.md
Name: aes192_key_schedule_ctrl

Overview:
- Iterative AES-192 key-schedule controller. Loads a 192-bit cipher key and drives the existing single-step key_expansion_192v datapath once per cycle for 8 steps.
- Stores the resulting 54-word schedule; words 0..51 are used.
- Serves the 13 round keys (128 bits each) to the cipher/decipher round engines through a registered read port.
- Sits between key-load logic and the AES-192 round datapath.

Parameters:
- NR, 12, number of AES-192 rounds; round keys 0..NR are readable (fixed for AES-192, not for reuse).
- NSTEP, 8, number of expansion steps; 6 + 6*NSTEP = 54 words stored.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load key_in and begin expansion; accepted only in IDLE or DONE
- clear  in  1  synchronous zeroize: wipe schedule, return to IDLE; has priority over start
- key_in  in  192  cipher key; bits [191:160] = w0 ... bits [31:0] = w5
- busy  out  1  high while in EXPAND
- done  out  1  one-cycle pulse when the schedule completes
- keys_valid  out  1  high in DONE; round keys readable
- rk_addr  in  4  round-key index 0..12
- rk_data  out  128  round key rk_addr, registered; bits [127:96] = w[4*rk_addr], down to bits [31:0] = w[4*rk_addr+3]

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, step counter=0.
  - All 54 stored words = 0.
  - busy=0, done=0, keys_valid=0, rk_data=0.
- States:
  - IDLE: start → EXPAND.
  - EXPAND: after the 8th step → DONE. start is ignored.
  - DONE: start → EXPAND (re-key).
  - clear in any state → IDLE.
- Start cycle (cycle 0):
  - key_in is latched into w0..w5.
  - Step counter = 0; keys_valid drops next cycle.
- Expansion cycles 1..8, step i = 0..7:
  - The datapath input is the previous group w[6i..6i+5], packed w[6i] at [191:160].
  - rcon = {RC[i], 24'h0}, with RC = 01,02,04,08,10,20,40,80.
  - The datapath output is written to w[6i+6..6i+11].
  - One step per cycle; combinational datapath; no stall.
- Completion:
  - busy is high for exactly cycles 1..8.
  - At the end of cycle 8, state → DONE.
  - done=1 for cycle 9 only; keys_valid=1 from cycle 9 onward.
  - Start-to-done latency is 9 cycles.
- Read port:
  - rk_data is updated each clock from rk_addr (1-cycle latency).
  - If keys_valid=0, or if rk_addr > 12, rk_data = 0.
  - Words 52,53 are never visible.
- Boundary conditions:
  - start and clear in the same cycle: clear wins; no load occurs.
  - start during EXPAND: ignored; no restart.
  - start in DONE: re-key. keys_valid falls in cycle 1; old keys are not readable during re-expansion.
  - Reset mid-EXPAND: immediate return to the reset state; no partial schedule is readable.
  - Step counter saturates; no wrap into step 8+.

Decomposition:
- Shared package aes_pkg:
  - AES-192 constants (NR=12, NK=6, word width 32).
  - The RC byte table (8 entries).
  - state enum {IDLE, EXPAND, DONE}.
- Sub-module: one instance of the existing key_expansion_192v.
  - The rcon mux, the word array (a 9x192 group register file) and the round-key read mux stay in this block.
- Read mux: round key r spans words 4r..4r+3, possibly across two 192-bit groups. Compute the group/offset mapping in a function in aes_pkg.

Test Plan:
- FIPS-197 A.2 key:
  - Stimulus: rst, then start with key_in=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - busy high for 8 cycles; done pulses 9 cycles after start; keys_valid=1 afterward.
- Readback after the A.2 load:
  - rk_addr=0 → rk_data=8e73b0f7da0e6452c810f32b809079e5 next cycle.
  - rk_addr=1 → rk_data[127:32]=62f8ead2522c6b7bfe0c91f7.
  - rk_addr=12 → rk_data=e98ba06f448c773c8ecc720401002202.
- Reads before keys_valid and out of range:
  - rk_addr=5 before any start → 0.
  - rk_addr=13 and 15 after done → 0.
- Start during EXPAND:
  - Pulse start with key_in=0 at cycle 4 of an A.2 expansion.
  - Ignored; rk 12 still = e98ba06f448c773c8ecc720401002202.
- Clear and re-key:
  - clear in DONE: keys_valid=0 and all reads 0; a following start with key_in=0 expands normally.
  - start and clear together: stays IDLE, done never pulses.
- Async reset at cycle 5 of EXPAND:
  - busy=0, done=0, keys_valid=0 immediately.
  - A following A.2 start completes correctly in 9 cycles.
